// File: rtl/latch_q_sync_filter.sv
// latch_q_sync_filter: synchronizes a latch q/qbar pair, debounces q, and reports edges, counts and q/qbar disagreement
module latch_q_sync_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_in,
   input  logic             qbar_in,
   input  logic             clr,
   output logic             q_sync,
   output logic             q_filt,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] edge_count,
   output logic             mismatch
);
   localparam int CW = $clog2(STABLE_CYCLES);
   typedef enum logic [1:0] {LOW, PEND_H, HIGH, PEND_L} state_t;
   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sq, sqb;
   logic                   s, sb, eq_d, acc_r, acc_f;
   assign s      = sq[SYNC_STAGES-1];
   assign sb     = sqb[SYNC_STAGES-1];
   assign q_sync = s;
   always_comb begin
      acc_r = state == PEND_H && s && cnt == CW'(STABLE_CYCLES - 1);
      acc_f = state == PEND_L && !s && cnt == CW'(STABLE_CYCLES - 1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sq         <= '0;
         sqb        <= '0;
         state      <= LOW;
         cnt        <= '0;
         eq_d       <= 1'b0;
         q_filt     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         edge_count <= '0;
         mismatch   <= 1'b0;
      end else begin
         sq         <= {sq[SYNC_STAGES-2:0], q_in};
         sqb        <= {sqb[SYNC_STAGES-2:0], qbar_in};
         eq_d       <= s == sb;
         rise_pulse <= acc_r;
         fall_pulse <= acc_f;
         q_filt     <= acc_r ? 1'b1 : acc_f ? 1'b0 : q_filt;
         mismatch   <= clr ? 1'b0 : mismatch | (eq_d && s == sb);
         // clr beats a same-cycle acceptance; the counter sticks at all-ones
         if (clr)
            edge_count <= '0;
         else if ((acc_r || acc_f) && edge_count != '1)
            edge_count <= edge_count + 1'b1;
         case (state)
            LOW:
               if (s) begin
                  state <= PEND_H;
                  cnt   <= CW'(1);
               end
            PEND_H:
               if (!s) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (acc_r) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else
                  cnt <= cnt + 1'b1;
            HIGH:
               if (!s) begin
                  state <= PEND_L;
                  cnt   <= CW'(1);
               end
            PEND_L:
               if (s) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (acc_f) begin
                  state <= LOW;
                  cnt   <= '0;
               end else
                  cnt <= cnt + 1'b1;
            default: begin
               state <= LOW;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_latch_q_sync_filter.sv
// tb_latch_q_sync_filter: directed and random stimulus checked against a run-length reference model
module tb_latch_q_sync_filter;
   localparam int SS = 2;
   localparam int ST = 4;
   localparam int CW = 3;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          q_in = 1'b0;
   logic          qbar_in = 1'b1;
   logic          clr = 1'b0;
   logic          q_sync, q_filt, rise_pulse, fall_pulse, mismatch;
   logic [CW-1:0] edge_count;
   int            tests = 0;
   int            fails = 0;
   logic          qh[$];
   logic          qbh[$];
   int            run, cnt, rises, falls;
   logic          filt, mm, eqd, er, ef;

   latch_q_sync_filter #(.SYNC_STAGES(SS), .STABLE_CYCLES(ST), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .q_in(q_in), .qbar_in(qbar_in), .clr(clr),
      .q_sync(q_sync), .q_filt(q_filt), .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse), .edge_count(edge_count), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic mreset();
      qh.delete();
      qbh.delete();
      repeat (SS) begin
         qh.push_back(1'b0);
         qbh.push_back(1'b0);
      end
      filt = 1'b0; run = 0; cnt = 0; mm = 1'b0; eqd = 1'b0; er = 1'b0; ef = 1'b0;
   endtask

   // s seen at an edge is the q_in sampled SS edges earlier; a level flips after ST contrary samples in a row
   task automatic tick(input logic qi, input logic qbi, input logic cl, input logic r);
      logic s_m, sb_m;
      q_in = qi; qbar_in = qbi; clr = cl; rst = r;
      @(posedge clk);
      if (r) mreset();
      else begin
         s_m = qh[SS-1];
         sb_m = qbh[SS-1];
         er = 1'b0;
         ef = 1'b0;
         run = (s_m != filt) ? run + 1 : 0;
         if (run == ST) begin
            er = s_m; ef = !s_m; filt = s_m; run = 0;
         end
         if (cl) cnt = 0;
         else if ((er || ef) && cnt < (1 << CW) - 1) cnt++;
         if (cl) mm = 1'b0;
         else if (eqd && s_m == sb_m) mm = 1'b1;
         eqd = s_m == sb_m;
         qh.push_front(qi); void'(qh.pop_back());
         qbh.push_front(qbi); void'(qbh.pop_back());
      end
      #1;
      chk("q_sync", 8'(q_sync), 8'(qh[SS-1]));
      chk("q_filt", 8'(q_filt), 8'(filt));
      chk("rise_pulse", 8'(rise_pulse), 8'(er));
      chk("fall_pulse", 8'(fall_pulse), 8'(ef));
      chk("edge_count", 8'(edge_count), 8'(cnt));
      chk("mismatch", 8'(mismatch), 8'(mm));
      rises += int'(rise_pulse === 1'b1);
      falls += int'(fall_pulse === 1'b1);
   endtask

   task automatic hold(input logic qi, input int n);
      repeat (n) tick(qi, !qi, 1'b0, 1'b0);
   endtask

   initial begin
      int r0, f0, len;
      logic v;
      rises = 0; falls = 0;
      mreset();
      // reset with an undefined latch, then a defined high level
      tick(1'bx, 1'bx, 1'b0, 1'b1);
      repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst_filt", 8'(q_filt), 8'd0);
      chk("rst_count", 8'(edge_count), 8'd0);
      hold(1'b1, 8);
      chk("rst_rise_once", 8'(rises), 8'd1);
      chk("rst_count_one", 8'(edge_count), 8'd1);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      chk("clr_count", 8'(edge_count), 8'd0);
      chk("clr_mismatch", 8'(mismatch), 8'd0);
      // glitch rejection
      hold(1'b0, 8);
      chk("low_filt", 8'(q_filt), 8'd0);
      r0 = rises; f0 = falls;
      hold(1'b1, 3);
      hold(1'b0, 8);
      chk("glitch_rise", 8'(rises - r0), 8'd0);
      chk("glitch_filt", 8'(q_filt), 8'd0);
      hold(1'b1, 4);
      hold(1'b0, 8);
      chk("pulse4_rise", 8'(rises - r0), 8'd1);
      chk("pulse4_fall", 8'(falls - f0), 8'd1);
      // abort mid-pending
      r0 = rises;
      hold(1'b1, 2);
      hold(1'b0, 1);
      hold(1'b1, 4);
      hold(1'b1, 4);
      chk("abort_rise", 8'(rises - r0), 8'd1);
      chk("abort_filt", 8'(q_filt), 8'd1);
      // saturation
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      r0 = rises + falls;
      for (int i = 0; i < 10; i++) hold(i[0] ? 1'b1 : 1'b0, 6);
      hold(1'b1, 6);
      chk("sat_pulses", 8'(rises + falls - r0), 8'd10);
      chk("sat_count", 8'(edge_count), 8'd7);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      chk("sat_clr", 8'(edge_count), 8'd0);
      // mismatch: a one-cycle overlap is ignored, three cycles latch the flag
      hold(1'b0, 8);
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      hold(1'b0, 6);
      chk("mm_short", 8'(mismatch), 8'd0);
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
      hold(1'b0, 6);
      chk("mm_long", 8'(mismatch), 8'd1);
      hold(1'b0, 5);
      chk("mm_sticky", 8'(mismatch), 8'd1);
      // clr on the acceptance edge
      hold(1'b1, SS + ST - 1);
      tick(1'b1, 1'b0, 1'b1, 1'b0);
      chk("clr_acc_rise", 8'(rise_pulse), 8'd1);
      chk("clr_acc_count", 8'(edge_count), 8'd0);
      chk("clr_acc_mm", 8'(mismatch), 8'd0);
      // reset while a rise is pending
      hold(1'b0, 8);
      r0 = rises;
      hold(1'b1, SS + 2);
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      chk("rstp_filt", 8'(q_filt), 8'd0);
      chk("rstp_rise", 8'(rises - r0), 8'd0);
      hold(1'b1, SS + ST - 1);
      chk("rstp_early", 8'(q_filt), 8'd0);
      hold(1'b1, 1);
      chk("rstp_accept", 8'(rise_pulse), 8'd1);
      // random runs with occasional overlap and clear
      for (int i = 0; i < 60; i++) begin
         v = 1'($urandom_range(1, 0));
         len = int'($urandom_range(7, 1));
         repeat (len)
            tick(v, ($urandom_range(9, 0) == 0) ? v : !v, $urandom_range(19, 0) == 0, 1'b0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
